// File: rtl/pipe_stage_buf.sv
// Purpose : generic pipeline stage register, valid/ready on both sides, 2-entry skid buffer.
// Latency : 1 cycle from input acceptance to out_valid when empty; 1 beat/cycle sustained.
// Backpressure: in_ready is a registered output (no comb path from out_ready); a second
//               beat is absorbed in the skid entry while the first waits downstream.
//
// Ports:
//   clk, rst                     clock (rising edge), async active-high reset
//   flush                        drop every held and incoming beat this cycle
//   in_valid/in_ready/in_data    upstream handshake and payload
//   out_valid/out_ready/out_data downstream handshake and payload
//   stall_cnt, flush_cnt         saturating perf counters, present only when
//                                PIPE_STAGE_BUF_PERF_EN is defined
module pipe_stage_buf #(
  parameter int DATA_W        = 96,
  parameter int ZERO_ON_FLUSH = 1,
  parameter int CNT_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_BUF_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  // Encoding chosen so bit0 = main entry valid, bit1 = skid entry valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   main_d;
  logic [DATA_W-1:0]   skid_d;
  logic                main_v;
  logic                skid_v;
  logic                in_fire;
  logic                out_fire;
  logic                load_main_in;
  logic                load_main_skid;
  logic                load_skid;

  if (DATA_W < 1 || CNT_W < 1 || ZERO_ON_FLUSH < 0 || ZERO_ON_FLUSH > 1) begin : g_param_check
    $error("pipe_stage_buf: illegal parameter value");
  end

  assign main_v    = (state != EMPTY);
  assign skid_v    = (state == FULL);

  // Both decode straight from the state register, so upstream never sees out_ready.
  assign in_ready  = ~skid_v;
  assign out_valid = main_v;
  assign out_data  = main_d;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_nxt    = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          // Downstream stalled: park the new beat behind the head.
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the skid beat can advance.
        if (out_fire) begin
          state_nxt      = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
    // Flush wins over everything; an out_fire this cycle has already been consumed.
    if (flush) begin
      state_nxt      = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_d <= '0;
      skid_d <= '0;
    end else if (flush) begin
      if (ZERO_ON_FLUSH != 0) begin
        main_d <= '0;
        skid_d <= '0;
      end
    end else begin
      if (load_main_in) begin
        main_d <= in_data;
      end else if (load_main_skid) begin
        main_d <= skid_d;
      end
      if (load_skid) begin
        skid_d <= in_data;
      end
    end
  end

`ifdef PIPE_STAGE_BUF_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Counters deliberately ignore flush: they track history across flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (flush && (main_v || skid_v) && flush_cnt != CNT_MAX) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

  localparam int DW   = 96;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
`endif

  pipe_stage_buf #(
    .DATA_W(DW),
    .ZERO_ON_FLUSH(1),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
`ifdef PIPE_STAGE_BUF_PERF_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: an in-order queue of at most two beats plus the last head value.
  logic [DW-1:0] q[$];
  logic [DW-1:0] hold;
  int            m_stall;
  int            m_flush;

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    q.delete();
    hold    = '0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // Drive one cycle starting just after a falling edge; advance the model at the rising edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    bit vld_now;
    bit rdy_now;
    vld_now   = (q.size() > 0);
    rdy_now   = (q.size() < 2);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    if (vld_now && !r && m_stall < CMAX) m_stall++;
    if (f) begin
      if (vld_now && m_flush < CMAX) m_flush++;
      q.delete();
      hold = '0;
    end else begin
      if (vld_now && r) void'(q.pop_front());
      if (v && rdy_now) q.push_back(d);
      if (q.size() > 0) hold = q[0];
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_stream();
    logic [DW-1:0] v1, v2, v3;
    v1 = 1; v2 = 2; v3 = 3;
    step(1'b1, v1, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== v1) begin errors++; $display("FAIL stream_1: got v=%b d=%h want v=1 d=1", out_valid, out_data); end
    step(1'b1, v2, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== v2 || in_ready !== 1'b1) begin errors++; $display("FAIL stream_2: got v=%b d=%h rdy=%b want v=1 d=2 rdy=1", out_valid, out_data, in_ready); end
    step(1'b1, v3, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== v3 || in_ready !== 1'b1) begin errors++; $display("FAIL stream_3: got v=%b d=%h rdy=%b want v=1 d=3 rdy=1", out_valid, out_data, in_ready); end
    step(1'b0, '0, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a, b, c;
    a = 'hA; b = 'hB; c = 'hC;
    step(1'b1, a, 1'b0, 1'b0);
    checks++; if (out_data !== a || in_ready !== 1'b1) begin errors++; $display("FAIL bp_one: got d=%h rdy=%b want d=a rdy=1", out_data, in_ready); end
    step(1'b1, b, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b0 || out_data !== a) begin errors++; $display("FAIL bp_full: got rdy=%b d=%h want rdy=0 d=a", in_ready, out_data); end
    step(1'b1, c, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b0 || out_data !== a || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold: got rdy=%b d=%h v=%b want rdy=0 d=a v=1", in_ready, out_data, out_valid); end
    step(1'b1, c, 1'b1, 1'b0);
    checks++; if (out_data !== b || in_ready !== 1'b1) begin errors++; $display("FAIL bp_second: got d=%h rdy=%b want d=b rdy=1", out_data, in_ready); end
    step(1'b1, c, 1'b1, 1'b0);
    checks++; if (out_data !== c || out_valid !== 1'b1) begin errors++; $display("FAIL bp_third: got d=%h v=%b want d=c v=1", out_data, out_valid); end
    step(1'b0, '0, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_flush_full();
    logic [DW-1:0] a, b, d;
    a = 'hA; b = 'hB; d = 'hD;
    step(1'b1, a, 1'b0, 1'b0);
    step(1'b1, b, 1'b0, 1'b0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_full: got rdy=%b want 0", in_ready); end
    step(1'b1, d, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin errors++; $display("FAIL flush_after: got v=%b rdy=%b d=%h want v=0 rdy=1 d=0", out_valid, in_ready, out_data); end
    step(1'b0, '0, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL flush_no_ghost: got v=%b d=%h want v=0 d=0", out_valid, out_data); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] a, b, e;
    a = rnd_data(); b = rnd_data(); e = 'h5;
    step(1'b1, a, 1'b0, 1'b0);
    step(1'b1, b, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin errors++; $display("FAIL reset_mid_async: got v=%b rdy=%b d=%h want v=0 rdy=1 d=0", out_valid, in_ready, out_data); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b1, e, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== e) begin errors++; $display("FAIL reset_mid_resume: got v=%b d=%h want v=1 d=5", out_valid, out_data); end
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      logic          v, r, f;
      logic [DW-1:0] d;
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 9) < 6);
      f = ($urandom_range(0, 24) == 0);
      d = rnd_data();
      step(v, d, r, f);
      checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rand_valid[%0d]: got %b want %b", i, out_valid, (q.size() > 0)); end
      checks++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", i, in_ready, (q.size() < 2)); end
      checks++; if (out_data !== hold) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", i, out_data, hold); end
    end
  endtask

`ifdef PIPE_STAGE_BUF_PERF_EN
  task automatic test_perf();
    logic [DW-1:0] a;
    a = 'hA;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++; if (stall_cnt !== '0 || flush_cnt !== '0) begin errors++; $display("FAIL perf_reset: got stall=%0d flush=%0d want 0 0", stall_cnt, flush_cnt); end
    step(1'b1, a, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b0);
    checks++; if (stall_cnt !== 4'd5) begin errors++; $display("FAIL perf_stall5: got %0d want 5", stall_cnt); end
    step(1'b0, '0, 1'b1, 1'b1);
    checks++; if (flush_cnt !== 4'd1 || stall_cnt !== 4'd5) begin errors++; $display("FAIL perf_flush1: got flush=%0d stall=%0d want 1 5", flush_cnt, stall_cnt); end
    step(1'b0, '0, 1'b1, 1'b1);
    checks++; if (flush_cnt !== 4'd1) begin errors++; $display("FAIL perf_flush_empty: got %0d want 1", flush_cnt); end
    step(1'b1, a, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0);
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL perf_saturate: got %0d want 15", stall_cnt); end
    checks++; if (int'(stall_cnt) !== m_stall || int'(flush_cnt) !== m_flush) begin errors++; $display("FAIL perf_model: got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, m_stall, m_flush); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_reset_mid();
    test_random();
`ifdef PIPE_STAGE_BUF_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
